// File: rtl/sar_adc_pkg.sv
// Shared types and defaults for the SAR ADC controller.
// Also used by the optional comparator synchronizer (SAR_ADC_CMP_SYNC_EN).
package sar_adc_pkg;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SAMPLE_CYCLES = 4;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int CMP_SYNC_DEPTH    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_DONE
    } sar_state_t;

endpackage

// File: rtl/sar_adc_ctrl_cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output.
// Only compiled and used when SAR_ADC_CMP_SYNC_EN is defined.
`ifdef SAR_ADC_CMP_SYNC_EN
module cmp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`endif

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller driving the R-2R DAC and reading the comparator MSB first.
// Define SAR_ADC_CMP_SYNC_EN to synchronize cmp_in and stretch each settle phase by the sync depth.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             sample_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

`ifdef SAR_ADC_CMP_SYNC_EN
    localparam int SETTLE_LEN = SETTLE_CYCLES + CMP_SYNC_DEPTH;
`else
    localparam int SETTLE_LEN = SETTLE_CYCLES;
`endif
    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_LEN) ? SAMPLE_CYCLES : SETTLE_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY    = {1'b1, {(WIDTH-1){1'b0}}};

    sar_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_trial;
    logic [WIDTH-1:0] r_dac_code;
    logic             r_sample_en;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;

    logic             w_cmp;
    logic [WIDTH-1:0] w_bit_mask;
    logic [WIDTH-1:0] w_trial_dec;
    logic [WIDTH-1:0] w_trial_next;

`ifdef SAR_ADC_CMP_SYNC_EN
    cmp_sync u_cmp_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (cmp_in),
        .o_sync  (w_cmp)
    );
`else
    assign w_cmp = cmp_in;
`endif

    // Trial for the bit under test with the decision applied, then the next lower bit set.
    assign w_bit_mask   = WIDTH'(1) << r_idx;
    assign w_trial_dec  = w_cmp ? r_trial : (r_trial & ~w_bit_mask);
    assign w_trial_next = w_trial_dec | (w_bit_mask >> 1);

    // NOTE: all state and outputs use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= IDX_TOP;
            r_trial     <= '0;
            r_dac_code  <= '0;
            r_sample_en <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_SAMPLE;
                        r_cnt       <= '0;
                        r_sample_en <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (r_cnt == SAMPLE_LAST) begin
                        r_state     <= ST_SETTLE;
                        r_cnt       <= '0;
                        r_sample_en <= 1'b0;
                        r_idx       <= IDX_TOP;
                        r_trial     <= MSB_ONLY;
                        r_dac_code  <= MSB_ONLY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_state <= ST_DECIDE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DECIDE: begin
                    if (r_idx == '0) begin
                        r_state    <= ST_DONE;
                        r_trial    <= w_trial_dec;
                        r_result   <= w_trial_dec;
                        r_done     <= 1'b1;
                        r_dac_code <= '0;
                    end else begin
                        r_state    <= ST_SETTLE;
                        r_idx      <= r_idx - 1'b1;
                        r_trial    <= w_trial_next;
                        r_dac_code <= w_trial_next;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_dac_code  <= '0;
                    r_sample_en <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign dac_code  = r_dac_code;
    assign sample_en = r_sample_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;

endmodule
